// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte channel, imem write port and run/status lines of the program loader
//   load_req, byte_valid, byte_data : host -> loader (load start pulse and byte stream)
//   byte_ready                      : loader -> host (byte accepted this cycle)
//   imem_we, imem_addr, imem_wdata  : loader -> instruction memory write port
//   run, busy, error                : loader -> CPU / host status
//   slave modport is the loader side, master modport is the host side
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  load_req;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  run;
  logic                  busy;
  logic                  error;
  modport slave (
    input  load_req, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, run, busy, error
  );
  modport master (
    output load_req, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, run, busy, error
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader writing big-endian words into imem, then raising run
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : imem_loader_if.slave (host byte channel, imem write port, run/busy/error)
//   Stream: 2-byte big-endian word count N, then N big-endian 32-bit words.
//   IMEM_LOADER_CHECKSUM_EN: when defined, one trailing byte must equal the XOR of all data bytes.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input logic         clk,
  input logic         rst_n,
  imem_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HDR, DATA, CKSUM, RUN, ERR} state_t;
  localparam logic [31:0] CAP = 32'd1 << ADDR_WIDTH;
  state_t                state_q;
  logic [1:0]            bcnt_q;
  logic [7:0]            hi_q;
  logic [23:0]           part_q;
  logic [15:0]           n_q;
  logic [15:0]           wcnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  we_q;
  logic                  run_q;
  logic                  err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            xor_q;
`endif
  logic                  xfer;
  logic                  last_word;
  logic [31:0]           word_d;
  logic [15:0]           n_d;
  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign word_d    = {part_q, bus.byte_data};
  assign n_d       = {hi_q, bus.byte_data};
  // wcnt_q counts words already assembled, so it reaches N during the final write pulse
  assign last_word = wcnt_q == n_q;
  assign bus.byte_ready = state_q == HDR || state_q == CKSUM || (state_q == DATA && !last_word);
  assign bus.busy       = state_q == HDR || state_q == DATA || state_q == CKSUM;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.run        = run_q;
  assign bus.error      = err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      hi_q    <= '0;
      part_q  <= '0;
      n_q     <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      // step the address after each pulse, but hold it on the final word so it never wraps
      if (we_q && !last_word) addr_q <= addr_q + ADDR_WIDTH'(1);
      if (bus.load_req) begin
        state_q <= HDR;
        bcnt_q  <= '0;
        part_q  <= '0;
        wcnt_q  <= '0;
        addr_q  <= '0;
        run_q   <= 1'b0;
        err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_q   <= '0;
`endif
      end else begin
        case (state_q)
          HDR: if (xfer) begin
            hi_q   <= bus.byte_data;
            bcnt_q <= bcnt_q[0] ? 2'd0 : 2'd1;
            if (bcnt_q[0]) begin
              n_q <= n_d;
              if (32'(n_d) > CAP) begin
                state_q <= ERR;
                err_q   <= 1'b1;
              end else state_q <= DATA;
            end
          end
          DATA: if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q <= CKSUM;
`else
            state_q <= RUN;
            run_q   <= 1'b1;
`endif
          end else if (xfer) begin
            part_q <= word_d[23:0];
            bcnt_q <= bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q  <= xor_q ^ bus.byte_data;
`endif
            if (bcnt_q == 2'd3) begin
              we_q    <= 1'b1;
              wdata_q <= word_d;
              wcnt_q  <= wcnt_q + 16'd1;
            end
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          CKSUM: if (xfer) begin
            state_q <= bus.byte_data == xor_q ? RUN : ERR;
            run_q   <= bus.byte_data == xor_q;
            err_q   <= bus.byte_data != xor_q;
          end
`endif
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a stream-level reference model
module tb_imem_loader;
  localparam int AW  = 4;
  localparam int CAP = 1 << AW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();
  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int last_we_cyc = -1;
  int acc_cyc = -1;
  int hdr_cyc = -1;
  int overlap = 0;
  logic run_prev = 1'b0;
  int wa[$];
  logic [31:0] wd[$];
  logic [31:0] words [0:CAP+3];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.imem_we) begin
      wa.push_back(int'(bus.imem_addr));
      wd.push_back(bus.imem_wdata);
      last_we_cyc = cyc;
      if (bus.run) overlap++;
    end
    if (bus.run && !run_prev) rise_cyc = cyc;
    run_prev = bus.run;
  endtask
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && t < 50) begin
      step();
      t++;
    end
    if (t == 50) chk("ready_timeout", 0, 1);
    acc_cyc = cyc;
    step();
    bus.byte_valid = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) step();
  endtask
  task automatic pulse_load(input bit junk);
    bus.load_req   = 1'b1;
    bus.byte_valid = junk;
    bus.byte_data  = 8'hFF;
    step();
    bus.load_req   = 1'b0;
    bus.byte_valid = 1'b0;
    wa.delete();
    wd.delete();
    rise_cyc = -1;
    last_we_cyc = -1;
    overlap = 0;
    chk("load_run", bus.run, 0);
    chk("load_err", bus.error, 0);
    chk("load_busy", bus.busy, 1);
  endtask
  task automatic run_load(input int n, input bit gaps, input bit junk, input bit bad_ck);
    logic [15:0] nn;
    logic [7:0] ck;
    logic [31:0] w;
    int tmo;
    int exp_w;
    bit exp_err;
    nn = 16'(n);
    ck = 8'h00;
    tmo = 0;
    pulse_load(junk);
    send_byte(nn[15:8], gaps);
    send_byte(nn[7:0], gaps);
    hdr_cyc = acc_cyc;
    exp_err = n > CAP;
    exp_w = exp_err ? 0 : n;
    for (int i = 0; i < exp_w; i++) begin
      w = words[i];
      for (int j = 0; j < 4; j++) begin
        ck ^= w[31-8*j -: 8];
        send_byte(w[31-8*j -: 8], gaps);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!exp_err) begin
      send_byte(bad_ck ? ck ^ 8'h01 : ck, gaps);
      exp_err = bad_ck;
    end
`endif
    while (!bus.run && !bus.error && tmo < 40) begin
      step();
      tmo++;
    end
    chk("done", tmo < 40, 1);
    chk("run", bus.run, !exp_err);
    chk("error", bus.error, exp_err);
    chk("busy", bus.busy, 0);
    chk("ready", bus.byte_ready, 0);
    chk("nwrites", wa.size(), exp_w);
    for (int i = 0; i < wa.size() && i < exp_w; i++) begin
      chk("waddr", wa[i], i);
      chk("wdata", wd[i], words[i]);
    end
    chk("overlap", overlap, 0);
    if (!exp_err) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("run_lat", rise_cyc, acc_cyc + 1);
`else
      if (n == 0) chk("run_lat0", rise_cyc, hdr_cyc + 2);
      else begin
        chk("we_lat", last_we_cyc, acc_cyc + 1);
        chk("run_lat", rise_cyc, last_we_cyc + 1);
      end
`endif
    end
  endtask
  initial begin
    int bad;
    int n;
    bus.load_req   = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.byte_ready, 0);
    chk("rst_we", bus.imem_we, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_wdata", bus.imem_wdata, 0);
    chk("rst_run", bus.run, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.error, 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      step();
      if (bus.run || bus.byte_ready || bus.imem_we) bad++;
    end
    chk("idle_quiet", bad, 0);
    words[0] = 32'h20080005;
    words[1] = 32'h01095020;
    run_load(2, 0, 0, 0);
    n = wa.size();
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h5A;
    repeat (5) begin
      step();
      chk("run_ignore_ready", bus.byte_ready, 0);
    end
    bus.byte_valid = 1'b0;
    chk("run_ignore_we", wa.size(), n);
    chk("run_hold", bus.run, 1);
    run_load(0, 0, 0, 0);
    run_load(CAP + 1, 0, 0, 0);
    repeat (3) step();
    chk("err_sticky", bus.error, 1);
    chk("err_norun", bus.run, 0);
    pulse_load(0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    words[0] = 32'hDEADBEEF;
    run_load(1, 0, 1, 0);
    words[0] = 32'h12345678;
    run_load(1, 0, 0, 0);
    run_load(1, 0, 0, 1);
    for (int i = 0; i < CAP; i++) words[i] = $urandom;
    run_load(CAP, 1, 0, 0);
    chk("last_addr", wa.size() == CAP ? wa[CAP-1] : -1, CAP - 1);
    for (int k = 0; k < 10; k++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, CAP + 3) : $urandom_range(1, CAP);
      for (int i = 0; i < CAP; i++) words[i] = $urandom;
      run_load(n, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream program loader that writes words into the CPU's instruction memory, then releases the processor by driving `run`. It is the write side of the instruction-memory interface whose read side is the datapath's fetch stage. It sits between a host byte channel (UART/JTAG bridge) and the imem write port. Its `run` output connects directly to the pipeline top's `run` input.

Parameters:
ADDR_WIDTH, 10, imem word-address width; capacity = 2^ADDR_WIDTH words.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
load_req  input  1  one-cycle pulse that starts (or restarts) a load.
byte_valid  input  1  host byte strobe.
byte_data  input  8  host byte.
byte_ready  output  1  loader accepts a byte this cycle.
imem_we  output  1  instruction-memory write enable, one-cycle pulse.
imem_addr  output  ADDR_WIDTH  word address for the write.
imem_wdata  output  32  instruction word.
run  output  1  CPU run enable.
busy  output  1  high in HDR, DATA and CKSUM.
error  output  1  sticky load-failure flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, run=0, busy=0, error=0.
  - Partial word, byte counter and word counter are all cleared.
- Handshake: a byte is transferred when byte_valid && byte_ready. byte_ready=1 only in HDR, DATA and CKSUM. Back-to-back bytes are accepted every cycle with no stall.
- State IDLE: waits for load_req, then goes to HDR. On entry to HDR: run=0, error=0, imem_addr=0, counters cleared.
- State HDR:
  - Accepts 2 bytes, big-endian, forming a 16-bit word count N.
  - N=0 goes straight to RUN; no imem writes occur.
  - N > 2^ADDR_WIDTH goes to ERR.
  - Otherwise goes to DATA.
- State DATA:
  - Bytes are assembled big-endian: the first byte goes to [31:24], the fourth to [7:0].
  - In the cycle after the 4th byte is accepted: imem_we=1 for exactly one cycle, imem_wdata=assembled word, imem_addr=current word index (0..N-1).
  - The address increments after each write pulse.
  - Acceptance of the next word's first byte may coincide with the write pulse.
  - After word N's write pulse, go to RUN (or to CKSUM when the feature is enabled). run=1 starting the cycle after the final write pulse; it is never asserted during or before any write.
- State RUN:
  - run=1 and byte_ready=0.
  - Bytes offered by the host are ignored (not accepted).
  - load_req: run=0 next cycle, go to HDR (reload).
- State ERR:
  - error=1, run=0, byte_ready=0.
  - Only load_req (back to HDR, error cleared) or reset exits.
- load_req while busy: aborts the current load, discards the partial word (no write pulse), restarts in HDR with imem_addr=0.
- imem_addr wraps are impossible: N is bounded by capacity, so N = 2^ADDR_WIDTH is legal and the last address is all-ones.
- Simultaneous load_req and byte transfer in the same cycle: load_req wins and the byte is dropped.

Optional Feature:
Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the final DATA word, state CKSUM accepts 1 byte.
  - The expected value is the XOR of every data byte accepted in DATA (header excluded).
  - Match goes to RUN. Mismatch goes to ERR (error=1, run=0); the already-written words remain in imem.
  - For N=0 the checksum byte is still required and must equal 8'h00.
- Undefined: no CKSUM state; DATA goes directly to RUN, and error is raised only by the oversize header.

Test Plan:
- Reset held, then released with no load_req → run=0, byte_ready=0, imem_we=0 for 20 cycles.
- load_req, then bytes 00 02 | 20 08 00 05 | 01 09 50 20 streamed back-to-back → two we pulses: addr0=0x20080005, addr1=0x01095020; run=1 the cycle after the second pulse; busy=0.
- Header 00 00 → no we pulse; run=1 two cycles after the second header byte is accepted.
- With ADDR_WIDTH=4, header 00 11 (17 words) → error=1, run=0, byte_ready=0; a later load_req clears error.
- load_req mid-word (after 2 of 4 data bytes), then header 00 01 and word DE AD BE EF → single we pulse at addr0 with data 0xDEADBEEF; no write of the partial word.
- CHECKSUM_EN, header 00 01, word 12 34 56 78, checksum 08 → run=1; the same stream with checksum 09 → error=1, run=0.
